// File: rtl/conv.sv
// conv: CNN feature extractor - 3x3 conv (two kernels, bias, ReLU), 2x2 max-pool, interleaved flatten.
// Image and layer memories are external; every output is registered.
module conv (
    input  logic        clk,
    input  logic        reset,
    output logic        busy,
    output logic [11:0] iaddr,
    input  logic [19:0] idata,
    output logic        cwr,
    output logic [11:0] caddr_wr,
    output logic [19:0] cdata_wr,
    output logic        crd,
    output logic [11:0] caddr_rd,
    input  logic [19:0] cdata_rd,
    output logic [2:0]  csel
);
    typedef enum logic [2:0] {IDLE, CONV, CWR0, CWR1, PRD, PWR1, PWR2, DONE} state_t;

    localparam logic [19:0] K0 [9] = '{20'h0A89E, 20'h092D5, 20'h06D43, 20'h01004, 20'hF8F71,
                                       20'hF6E54, 20'hFA6D7, 20'hFC834, 20'hFAC19};
    localparam logic [19:0] K1 [9] = '{20'hFDB55, 20'h02992, 20'hFC994, 20'h050FD, 20'h02F20,
                                       20'h0202D, 20'h03BD7, 20'hFD369, 20'h05E68};
    localparam logic [19:0] BIAS0 = 20'h01310;
    localparam logic [19:0] BIAS1 = 20'hF7295;

    state_t             state_q, state_d;
    logic [3:0]         t_q, t_d;
    logic [11:0]        pix_q, pix_d;
    logic [9:0]         pidx_q, pidx_d;
    logic               k_q, k_d;
    logic               vld_q, vld_d;
    logic signed [43:0] acc0_q, acc0_d, acc1_q, acc1_d;
    logic [19:0]        mx_q, mx_d;
    logic               busy_q, busy_d, cwr_q, cwr_d, crd_q, crd_d;
    logic [11:0]        iaddr_q, iaddr_d, caddr_wr_q, caddr_wr_d, caddr_rd_q, caddr_rd_d;
    logic [19:0]        cdata_wr_q, cdata_wr_d;
    logic [2:0]         csel_q, csel_d;

    logic [1:0]         tr, tc;
    logic [6:0]         rr, cc;
    logic [3:0]         pt;
    logic signed [39:0] p0, p1;

    function automatic logic [19:0] relu(input logic signed [43:0] a);
        return a[43] ? 20'h0 : a[35:16] + 20'(a[15]);
    endfunction

    // Tap t maps to (dr,dc) = (t/3-1, t%3-1); bit 6 of rr/cc flags a tap outside 0..63.
    always_comb begin
        tr = (t_q >= 4'd6) ? 2'd2 : (t_q >= 4'd3) ? 2'd1 : 2'd0;
        tc = (t_q == 4'd1 || t_q == 4'd4 || t_q == 4'd7) ? 2'd1 :
             (t_q == 4'd2 || t_q == 4'd5 || t_q == 4'd8) ? 2'd2 : 2'd0;
        rr = {1'b0, pix_q[11:6]} + {5'b0, tr} - 7'd1;
        cc = {1'b0, pix_q[5:0]} + {5'b0, tc} - 7'd1;
        pt = t_q - 4'd1;
        p0 = 40'($signed(idata)) * 40'($signed(K0[pt]));
        p1 = 40'($signed(idata)) * 40'($signed(K1[pt]));
    end

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        pix_d      = pix_q;
        pidx_d     = pidx_q;
        k_d        = k_q;
        vld_d      = 1'b0;
        acc0_d     = acc0_q;
        acc1_d     = acc1_q;
        mx_d       = mx_q;
        busy_d     = 1'b1;
        iaddr_d    = iaddr_q;
        cwr_d      = 1'b0;
        caddr_wr_d = caddr_wr_q;
        cdata_wr_d = cdata_wr_q;
        crd_d      = 1'b0;
        caddr_rd_d = caddr_rd_q;
        csel_d     = 3'b000;
        case (state_q)
            IDLE: state_d = CONV;
            CONV: begin
                // Address for tap t goes out now; its data arrives while t+1 is current.
                if (t_q == 4'd0) begin
                    acc0_d = {{8{BIAS0[19]}}, BIAS0, 16'h0};
                    acc1_d = {{8{BIAS1[19]}}, BIAS1, 16'h0};
                end else if (vld_q) begin
                    acc0_d = acc0_q + 44'(p0);
                    acc1_d = acc1_q + 44'(p1);
                end
                if (t_q == 4'd9) begin
                    t_d     = 4'd0;
                    state_d = CWR0;
                end else begin
                    t_d     = t_q + 4'd1;
                    iaddr_d = {rr[5:0], cc[5:0]};
                    vld_d   = !rr[6] && !cc[6];
                end
            end
            CWR0: begin
                cwr_d      = 1'b1;
                csel_d     = 3'b001;
                caddr_wr_d = pix_q;
                cdata_wr_d = relu(acc0_q);
                state_d    = CWR1;
            end
            CWR1: begin
                cwr_d      = 1'b1;
                csel_d     = 3'b010;
                caddr_wr_d = pix_q;
                cdata_wr_d = relu(acc1_q);
                pix_d      = pix_q + 12'd1;
                state_d    = (&pix_q) ? PRD : CONV;
            end
            PRD: begin
                if (t_q != 4'd0)
                    mx_d = (t_q == 4'd1 || $signed(cdata_rd) > $signed(mx_q)) ? cdata_rd : mx_q;
                if (t_q == 4'd4) begin
                    t_d     = 4'd0;
                    state_d = PWR1;
                end else begin
                    t_d        = t_q + 4'd1;
                    crd_d      = 1'b1;
                    csel_d     = k_q ? 3'b010 : 3'b001;
                    caddr_rd_d = {pidx_q[9:5], t_q[1], pidx_q[4:0], t_q[0]};
                end
            end
            PWR1: begin
                cwr_d      = 1'b1;
                csel_d     = k_q ? 3'b100 : 3'b011;
                caddr_wr_d = {2'b00, pidx_q};
                cdata_wr_d = mx_q;
                state_d    = PWR2;
            end
            PWR2: begin
                cwr_d      = 1'b1;
                csel_d     = 3'b101;
                caddr_wr_d = {1'b0, pidx_q, k_q};
                cdata_wr_d = mx_q;
                pidx_d     = pidx_q + 10'd1;
                k_d        = k_q | (&pidx_q);
                state_d    = (&pidx_q && k_q) ? DONE : PRD;
            end
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            t_q        <= 4'd0;
            pix_q      <= 12'd0;
            pidx_q     <= 10'd0;
            k_q        <= 1'b0;
            vld_q      <= 1'b0;
            acc0_q     <= 44'sd0;
            acc1_q     <= 44'sd0;
            mx_q       <= 20'd0;
            busy_q     <= 1'b0;
            iaddr_q    <= 12'd0;
            cwr_q      <= 1'b0;
            caddr_wr_q <= 12'd0;
            cdata_wr_q <= 20'd0;
            crd_q      <= 1'b0;
            caddr_rd_q <= 12'd0;
            csel_q     <= 3'b000;
        end else begin
            state_q    <= state_d;
            t_q        <= t_d;
            pix_q      <= pix_d;
            pidx_q     <= pidx_d;
            k_q        <= k_d;
            vld_q      <= vld_d;
            acc0_q     <= acc0_d;
            acc1_q     <= acc1_d;
            mx_q       <= mx_d;
            busy_q     <= busy_d;
            iaddr_q    <= iaddr_d;
            cwr_q      <= cwr_d;
            caddr_wr_q <= caddr_wr_d;
            cdata_wr_q <= cdata_wr_d;
            crd_q      <= crd_d;
            caddr_rd_q <= caddr_rd_d;
            csel_q     <= csel_d;
        end
    end

    assign busy     = busy_q;
    assign iaddr    = iaddr_q;
    assign cwr      = cwr_q;
    assign caddr_wr = caddr_wr_q;
    assign cdata_wr = cdata_wr_q;
    assign crd      = crd_q;
    assign caddr_rd = caddr_rd_q;
    assign csel     = csel_q;
endmodule

// File: tb/tb_conv.sv
// tb_conv: scoreboard bench for conv; one image combines the isolated-impulse, half-LSB,
// padding-corner and ReLU cases, with a reset abort mid-CONV before the full run.
module tb_conv;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        busy, cwr, crd;
    logic [11:0] iaddr, caddr_wr, caddr_rd;
    logic [19:0] idata, cdata_wr, cdata_rd;
    logic [2:0]  csel;

    typedef struct {
        logic [2:0]  sel;
        logic [11:0] addr;
        logic [19:0] data;
    } exp_t;

    logic [19:0] img [4096];
    logic [19:0] mem [8][4096];
    int          wcnt [8][4096];
    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          proto = 0;

    conv dut (
        .clk(clk), .reset(reset), .busy(busy), .iaddr(iaddr), .idata(idata),
        .cwr(cwr), .caddr_wr(caddr_wr), .cdata_wr(cdata_wr), .crd(crd),
        .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .csel(csel)
    );

    always #5 clk = ~clk;

    assign idata    = img[iaddr];
    assign cdata_rd = crd ? mem[csel][caddr_rd] : 20'h5A5A5;

    // Layer memories: poisoned on reset, write committed at the posedge where cwr=1.
    always @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < 8; s++)
                for (int a = 0; a < 4096; a++) begin
                    mem[s][a]  <= 20'hAAAAA;
                    wcnt[s][a] <= 0;
                end
        end else if (cwr) begin
            mem[csel][caddr_wr]  <= cdata_wr;
            wcnt[csel][caddr_wr] <= wcnt[csel][caddr_wr] + 1;
        end
        if (!reset && ((cwr && crd) || (cwr && (csel == 3'd0 || csel > 3'd5)) ||
                       (crd && (csel == 3'd0 || csel > 3'd2))))
            proto <= proto + 1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [2:0] sel, input logic [11:0] addr, input logic [19:0] data);
        exp_t e;
        e.sel  = sel;
        e.addr = addr;
        e.data = data;
        q.push_back(e);
    endtask

    // Monitor: each presented write consumes the matching expectation, if any.
    initial forever begin
        @(negedge clk);
        if (!reset && cwr)
            for (int i = 0; i < q.size(); i++)
                if (q[i].sel == csel && q[i].addr == caddr_wr) begin
                    chk($sformatf("wr sel%0d[%0d]", csel, caddr_wr), 32'(cdata_wr), 32'(q[i].data));
                    q.delete(i);
                    break;
                end
    end

    initial begin
        int n;
        int bad;
        int lim;
        foreach (img[i]) img[i] = 20'h0;
        img[650]  = 20'h10000;
        img[1300] = 20'h08000;
        for (int r = 40; r <= 44; r++)
            for (int c = 40; c <= 44; c++) img[r*64+c] = 20'h10000;
        img[62*64+62] = 20'h10000;
        img[62*64+63] = 20'h10000;
        img[63*64+62] = 20'h10000;
        img[4095]     = 20'h10000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy), 0);
        chk("rst cwr", 32'(cwr), 0);
        chk("rst crd", 32'(crd), 0);
        chk("rst csel", 32'(csel), 0);
        chk("rst iaddr", 32'(iaddr), 0);
        chk("rst caddr_wr", 32'(caddr_wr), 0);
        chk("rst caddr_rd", 32'(caddr_rd), 0);
        chk("rst cdata_wr", 32'(cdata_wr), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("busy after release", 32'(busy), 1);
        repeat (3000) @(negedge clk);
        chk("busy mid conv", 32'(busy), 1);

        reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("abort busy", 32'(busy), 0);
        chk("abort cwr", 32'(cwr), 0);
        chk("abort csel", 32'(csel), 0);

        push(3'd1, 12'd0,    20'h01310);
        push(3'd2, 12'd0,    20'h00000);
        push(3'd1, 12'd2000, 20'h01310);
        push(3'd1, 12'd715,  20'h0BBAE);
        push(3'd1, 12'd714,  20'h0A5E5);
        push(3'd1, 12'd651,  20'h02314);
        push(3'd1, 12'd650,  20'h00000);
        push(3'd2, 12'd715,  20'h00000);
        push(3'd1, 12'd1364, 20'h05C7B);
        push(3'd1, 12'd1365, 20'h0675F);
        push(3'd1, 12'd4095, 20'h0EDF8);
        push(3'd1, 12'd2730, 20'h00000);
        push(3'd2, 12'd2730, 20'h04F02);
        push(3'd3, 12'd0,    20'h01310);
        push(3'd4, 12'd0,    20'h00000);
        push(3'd3, 12'd165,  20'h0BBAE);
        push(3'd3, 12'd693,  20'h00000);
        push(3'd4, 12'd693,  20'h04F02);
        push(3'd5, 12'd0,    20'h01310);
        push(3'd5, 12'd1,    20'h00000);
        push(3'd5, 12'd330,  20'h0BBAE);
        push(3'd5, 12'd1386, 20'h00000);
        push(3'd5, 12'd1387, 20'h04F02);

        reset = 1'b0;
        @(negedge clk);
        chk("busy after restart", 32'(busy), 1);
        n = 0;
        while (busy && n < 90000) begin
            @(negedge clk);
            n++;
        end
        chk("done within budget", 32'(busy), 0);
        repeat (20) @(negedge clk);
        chk("busy stays low", 32'(busy), 0);
        chk("no write after done", 32'(cwr), 0);
        chk("unmatched expectations", 32'(q.size()), 0);
        for (int s = 1; s <= 5; s++) begin
            bad = 0;
            lim = (s <= 2) ? 4096 : (s <= 4) ? 1024 : 2048;
            for (int a = 0; a < 4096; a++)
                if (wcnt[s][a] != ((a < lim) ? 1 : 0)) bad++;
            chk($sformatf("write-once sel%0d", s), 32'(bad), 0);
        end
        chk("protocol violations", 32'(proto), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
